serial_harness_driver: RTL and testbench

Host-side initiator for the bit-serial primitive-test harness. The harness top exposes `di`, `stb` and `do`; it collects a `DIN_N`-bit stimulus from `di` into a shift register, latches that register onto the primitive's pins on `stb`, and on the same `stb` loads the primitive's `DOUT_N` outputs into a shift register that it clocks out on `do`. This block takes one parallel stimulus word and drives it serially into the harness. It issues the two strobes needed for a settled capture, deserialises the response from `do`, and returns it through a valid/ready handshake. It sits in the test fabric and connects directly to the harness pins with no registers in between.

---
 rtl/serial_harness_pkg.sv | 10 +
 rtl/serial_harness_shifter.sv | 33 +++
 rtl/serial_harness_driver.sv | 169 ++++++++++++++++
 tb/tb_serial_harness_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_harness_pkg.sv
// serial_harness_pkg: shared state encoding, default widths and latency helper for the harness driver
package serial_harness_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT1, STB1, SETTLE, SHIFT2, STB2, CAPT, RESP} state_e;
  localparam int DIN_N_DEF = 8;
  localparam int DOUT_N_DEF = 8;
  localparam int SETTLE_N_DEF = 0;
  function automatic int drv_latency(input int din_n, input int dout_n, input int settle_n);
    return 2 * din_n + settle_n + dout_n + 2;
  endfunction
endpackage

// File: rtl/serial_harness_shifter.sv
// serial_harness_shifter: loadable left shift register plus the shared per-state bit counter
module serial_harness_shifter #(
  parameter int W = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic          clr,
  input  logic [W-1:0]  load_val,
  output logic [W-1:0]  q,
  output logic [CW-1:0] cnt
);
  logic [W-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    q_d = load ? load_val : shift ? {q_q[W-2:0], sin} : q_q;
    cnt_d = clr ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q <= q_d;
      cnt_q <= cnt_d;
    end
  end
  assign q = q_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/serial_harness_driver.sv
// serial_harness_driver: serialises a stimulus word into the test harness twice, strobes, and deserialises the response
// Optional response compare/error counter enabled by defining SERIAL_HARNESS_CHECK_EN.
module serial_harness_driver import serial_harness_pkg::*; #(
  parameter int DIN_N = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIN_N-1:0]  req_din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DOUT_N-1:0] rsp_dout,
`ifdef SERIAL_HARNESS_CHECK_EN
  input  logic [DOUT_N-1:0] req_exp,
  input  logic [DOUT_N-1:0] req_mask,
  output logic              rsp_mismatch,
  output logic [15:0]       err_cnt,
`endif
  output logic              dut_di,
  output logic              dut_stb,
  input  logic              dut_do
);
  localparam int W = DIN_N > DOUT_N ? DIN_N : DOUT_N;
  localparam int MAXN = W > SETTLE_N ? W : SETTLE_N;
  localparam int CW = $clog2(MAXN + 1);
  localparam logic [CW-1:0] DIN_LAST = CW'(DIN_N - 1);
  localparam logic [CW-1:0] DOUT_LAST = CW'(DOUT_N - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_N > 0 ? SETTLE_N - 1 : 0);
  state_e state_q, state_d;
  logic [DIN_N-1:0] din_q, din_d;
  logic [DOUT_N-1:0] rsp_dout_q, rsp_dout_d, capt;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic dut_di_q, dut_di_d, dut_stb_q, dut_stb_d;
  logic sh_load, sh_shift, sh_clr;
  logic [W-1:0] sh_val, sh_q;
  logic [CW-1:0] cnt;
  serial_harness_shifter #(.W(W), .CW(CW)) u_shift (
    .clk(clk), .rst(rst), .load(sh_load), .shift(sh_shift), .sin(dut_do),
    .clr(sh_clr), .load_val(sh_val), .q(sh_q), .cnt(cnt)
  );
  assign capt = {sh_q[DOUT_N-2:0], dut_do};
  // The MSB goes straight to dut_di on load, so the shifter holds the remaining bits pre-shifted
  always_comb begin
    state_d = state_q;
    din_d = din_q;
    rsp_dout_d = rsp_dout_q;
    rsp_valid_d = 1'b0;
    dut_di_d = 1'b0;
    dut_stb_d = 1'b0;
    sh_load = 1'b0;
    sh_shift = 1'b0;
    sh_clr = 1'b0;
    sh_val = W'({din_q[DIN_N-2:0], 1'b0});
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        state_d = SHIFT1;
        din_d = req_din;
        sh_load = 1'b1;
        sh_val = W'({req_din[DIN_N-2:0], 1'b0});
        sh_clr = 1'b1;
        dut_di_d = req_din[DIN_N-1];
      end
      SHIFT1: begin
        sh_shift = 1'b1;
        dut_di_d = cnt == DIN_LAST ? 1'b0 : sh_q[DIN_N-1];
        if (cnt == DIN_LAST) begin
          state_d = STB1;
          dut_stb_d = 1'b1;
          sh_clr = 1'b1;
        end
      end
      STB1: begin
        sh_clr = 1'b1;
        if (SETTLE_N > 0) state_d = SETTLE;
        else begin
          state_d = SHIFT2;
          sh_load = 1'b1;
          dut_di_d = din_q[DIN_N-1];
        end
      end
      SETTLE: if (cnt == SETTLE_LAST) begin
        state_d = SHIFT2;
        sh_load = 1'b1;
        sh_clr = 1'b1;
        dut_di_d = din_q[DIN_N-1];
      end
      SHIFT2: begin
        sh_shift = 1'b1;
        dut_di_d = cnt == DIN_LAST ? 1'b0 : sh_q[DIN_N-1];
        if (cnt == DIN_LAST) begin
          state_d = STB2;
          dut_stb_d = 1'b1;
          sh_clr = 1'b1;
        end
      end
      STB2: begin
        state_d = CAPT;
        sh_clr = 1'b1;
      end
      CAPT: begin
        sh_shift = 1'b1;
        if (cnt == DOUT_LAST) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_dout_d = capt;
        end
      end
      RESP: begin
        rsp_valid_d = !rsp_ready;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      din_q <= '0;
      rsp_dout_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      dut_di_q <= 1'b0;
      dut_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q <= din_d;
      rsp_dout_q <= rsp_dout_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      dut_di_q <= dut_di_d;
      dut_stb_q <= dut_stb_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dout = rsp_dout_q;
  assign dut_di = dut_di_q;
  assign dut_stb = dut_stb_q;
`ifdef SERIAL_HARNESS_CHECK_EN
  logic [DOUT_N-1:0] exp_q, exp_d, mask_q, mask_d;
  logic mism_q, mism_d;
  logic [15:0] err_q, err_d;
  always_comb begin
    exp_d = state_q == IDLE && req_valid && req_ready_q ? req_exp : exp_q;
    mask_d = state_q == IDLE && req_valid && req_ready_q ? req_mask : mask_q;
    mism_d = state_q == RESP ? mism_q & !rsp_ready : rsp_valid_d & |((capt ^ exp_q) & mask_q);
    err_d = state_q == RESP && rsp_ready && mism_q && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      mask_q <= '0;
      mism_q <= 1'b0;
      err_q <= '0;
    end else begin
      exp_q <= exp_d;
      mask_q <= mask_d;
      mism_q <= mism_d;
      err_q <= err_d;
    end
  end
  assign rsp_mismatch = mism_q;
  assign err_cnt = err_q;
`endif
endmodule

// File: tb/tb_serial_harness_driver.sv
// tb_serial_harness_driver: drives two driver instances (SETTLE_N 0 and 3) against a behavioural harness whose primitive inverts its inputs
module tb_serial_harness_driver;
  logic clk = 1'b0;
  logic rst;
  logic req_valid [2];
  logic req_ready [2];
  logic rsp_valid [2];
  logic rsp_ready [2];
  logic dut_di [2];
  logic dut_stb [2];
  logic dut_do [2];
  logic [7:0] req_din [2];
  logic [7:0] rsp_dout [2];
  logic [7:0] hsr [2];
  logic [7:0] pins [2];
  logic [7:0] osr [2];
`ifdef SERIAL_HARNESS_CHECK_EN
  logic [7:0] req_exp [2];
  logic [7:0] req_mask [2];
  logic rsp_mismatch [2];
  logic [15:0] err_cnt [2];
  int err_exp [2];
`endif
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    serial_harness_driver #(.DIN_N(8), .DOUT_N(8), .SETTLE_N(g * 3)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_din(req_din[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_dout(rsp_dout[g]),
`ifdef SERIAL_HARNESS_CHECK_EN
      .req_exp(req_exp[g]), .req_mask(req_mask[g]),
      .rsp_mismatch(rsp_mismatch[g]), .err_cnt(err_cnt[g]),
`endif
      .dut_di(dut_di[g]), .dut_stb(dut_stb[g]), .dut_do(dut_do[g])
    );
    // harness: di shift-in, stb latches pins and loads the primitive output of the old pins
    always @(posedge clk) begin
      if (dut_stb[g]) begin
        osr[g] <= ~pins[g];
        pins[g] <= hsr[g];
      end else osr[g] <= {osr[g][6:0], 1'b0};
      hsr[g] <= {hsr[g][6:0], dut_di[g]};
    end
    assign dut_do[g] = osr[g][7];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic run_txn(input int s, input logic [7:0] din, input int stall, input int abort_at);
    int set = s * 3;
    int lat = 2 * 8 + set + 8 + 2;
    int s1 = -1, s2 = -1, sc = 0, trsp = -1, bad = 0;
    logic [15:0] diseq = '0;
    logic [7:0] nd = ~din;
    logic ok = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[s]), 1);
    req_valid[s] = 1'b1;
    req_din[s] = din;
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_din[s] = 8'($urandom);
    for (int n = 0; n < 100; n++) begin
      if (n == abort_at) begin
        chk("pre_rst_di", 32'(dut_di[s]), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_stb", 32'(dut_stb[s]), 0);
        chk("rst_async_di", 32'(dut_di[s]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef SERIAL_HARNESS_CHECK_EN
        err_exp = '{0, 0};
`endif
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready[s]), 1);
        for (int i = 0; i < 40; i++) begin
          if (dut_stb[s] || rsp_valid[s]) bad++;
          @(negedge clk);
        end
        chk("quiet_after_rst", bad, 0);
        return;
      end
      if (dut_stb[s]) begin
        sc++;
        if (s1 < 0) s1 = n;
        else s2 = n;
      end
      if (n < 8 || (n >= 9 + set && n < 17 + set)) diseq = {diseq[14:0], dut_di[s]};
      if (rsp_valid[s]) begin
        trsp = n;
        break;
      end
      @(negedge clk);
    end
    chk("di_seq", 32'(diseq), 32'({din, din}));
    chk("stb_count", sc, 2);
    chk("stb1_edge", s1, 8);
    chk("stb2_edge", s2, 17 + set);
    chk("rsp_latency", trsp, lat);
    chk("rsp_dout", 32'(rsp_dout[s]), 32'(nd));
`ifdef SERIAL_HARNESS_CHECK_EN
    chk("rsp_mismatch", 32'(rsp_mismatch[s]), 32'(|((nd ^ req_exp[s]) & req_mask[s])));
    if (|((nd ^ req_exp[s]) & req_mask[s])) err_exp[s]++;
`endif
    for (int i = 0; i < stall; i++) begin
      if (rsp_dout[s] !== nd || req_ready[s] !== 1'b0 || dut_stb[s] !== 1'b0 || rsp_valid[s] !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", 32'(ok), 1);
    rsp_ready[s] = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid[s]), 0);
    chk("back_to_idle", 32'(req_ready[s]), 1);
`ifdef SERIAL_HARNESS_CHECK_EN
    chk("err_cnt", 32'(err_cnt[s]), 32'(err_exp[s]));
`endif
  endtask
  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      rsp_ready[g] = 1'b0;
      req_din[g] = '0;
      hsr[g] = '0;
      pins[g] = '0;
      osr[g] = '0;
`ifdef SERIAL_HARNESS_CHECK_EN
      req_exp[g] = '0;
      req_mask[g] = '0;
      err_exp[g] = 0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", 32'(req_ready[g]), 0);
      chk("rst_rsp_valid", 32'(rsp_valid[g]), 0);
      chk("rst_rsp_dout", 32'(rsp_dout[g]), 0);
      chk("rst_dut_di", 32'(dut_di[g]), 0);
      chk("rst_dut_stb", 32'(dut_stb[g]), 0);
`ifdef SERIAL_HARNESS_CHECK_EN
      chk("rst_mismatch", 32'(rsp_mismatch[g]), 0);
      chk("rst_err_cnt", 32'(err_cnt[g]), 0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release0", 32'(req_ready[0]), 1);
    chk("ready_after_release1", 32'(req_ready[1]), 1);
    run_txn(0, 8'hA5, 0, -1);
    run_txn(0, 8'hA5, 5, -1);
    run_txn(0, 8'hFF, 0, 12);
    run_txn(0, 8'h3C, 0, -1);
    run_txn(1, 8'($urandom), 0, -1);
    run_txn(1, 8'h5A, 2, -1);
    for (int i = 0; i < 6; i++) run_txn(int'($urandom_range(1, 0)), 8'($urandom), int'($urandom_range(3, 0)), -1);
`ifdef SERIAL_HARNESS_CHECK_EN
    req_exp[0] = 8'h5A;
    req_mask[0] = 8'hFF;
    run_txn(0, 8'hA5, 0, -1);
    req_exp[0] = 8'h00;
    req_mask[0] = 8'h0F;
    run_txn(0, 8'hA5, 1, -1);
    req_exp[1] = 8'($urandom);
    req_mask[1] = 8'($urandom);
    run_txn(1, 8'($urandom), 0, -1);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
